// File: rtl/sort8_stream.sv
// Collects an 8-byte frame, sorts it in one cycle, replays it as an 8-beat stream.
// Latency: first output byte two cycles after the 8th input transfer; 17 cycles/frame unstalled.
// Backpressure: in_ready low outside LOAD; out_valid/out_data hold while out_ready is low.

module sort8 (
  input  logic [7:0][7:0] x,
  output logic [7:0][7:0] y
);
  logic [7:0] v [8];
  logic [7:0] t;

  // Odd-even transposition network: 8 alternating rounds fully sort 8 entries.
  always_comb begin
    t = '0;
    for (int i = 0; i < 8; i++) v[i] = x[i];
    for (int s = 0; s < 8; s++) begin
      for (int i = s % 2; i < 7; i += 2) begin
        if (v[i] > v[i+1]) begin
          t      = v[i];
          v[i]   = v[i+1];
          v[i+1] = t;
        end
      end
    end
    for (int i = 0; i < 8; i++) y[i] = v[i];
  end
endmodule

module sort8_stream #(
  parameter bit DESCEND = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       in_ready,
  output logic       out_valid,
  output logic [7:0] out_data,
  output logic       out_last,
  input  logic       out_ready,
  output logic       busy
);
  typedef enum logic [1:0] {LOAD, SORT, SEND} state_t;

  state_t          state;
  logic [2:0]      cnt;
  logic [2:0]      idx;
  logic [7:0]      ibuf [8];
  logic [7:0]      res  [8];
  logic [7:0][7:0] sx;
  logic [7:0][7:0] sy;

  always_comb begin
    for (int i = 0; i < 8; i++) sx[i] = ibuf[i];
  end

  sort8 u_sort8 (
    .x (sx),
    .y (sy)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= LOAD;
      cnt   <= '0;
      idx   <= '0;
      for (int i = 0; i < 8; i++) begin
        ibuf[i] <= '0;
        res[i]  <= '0;
      end
    end else begin
      case (state)
        LOAD: begin
          if (in_valid) begin
            ibuf[cnt] <= in_data;
            cnt       <= cnt + 3'd1;
            if (cnt == 3'd7) state <= SORT;
          end
        end
        SORT: begin
          for (int i = 0; i < 8; i++) res[i] <= sy[i];
          state <= SEND;
        end
        SEND: begin
          if (out_ready) begin
            idx <= idx + 3'd1;
            if (idx == 3'd7) state <= LOAD;
          end
        end
        default: state <= LOAD;
      endcase
    end
  end

  // All outputs decode registered state only; no path from in_valid/out_ready.
  assign in_ready  = (state == LOAD);
  assign out_valid = (state == SEND);
  assign out_last  = (state == SEND) && (idx == 3'd7);
  assign out_data  = DESCEND ? res[~idx] : res[idx];
  assign busy      = (state != LOAD) || (cnt != 3'd0);
endmodule

// File: tb/tb_sort8_stream.sv
// Randomized bench for sort8_stream: ascending and descending instances share one input stream,
// checked each cycle against a frame-level queue model.
module tb_sort8_stream;
  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [7:0] in_data;
  logic       out_ready;
  logic       in_ready, out_valid, out_last, busy;
  logic [7:0] out_data;
  logic       in_ready_d, out_valid_d, out_last_d, busy_d;
  logic [7:0] out_data_d;

  always #5 clk = ~clk;

  sort8_stream #(.DESCEND(1'b0)) dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_last(out_last), .out_ready(out_ready),
    .busy(busy)
  );
  sort8_stream #(.DESCEND(1'b1)) dut_d (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready_d),
    .out_valid(out_valid_d), .out_data(out_data_d), .out_last(out_last_d), .out_ready(out_ready),
    .busy(busy_d)
  );

  int n_pass = 0;
  int n_checks = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Reference model: bytes of the frame being loaded, and the sorted frame awaiting output.
  logic [7:0] frame [$];
  logic [7:0] asc [$];
  int         starts [$];
  int         beat = 0;
  int         cycle = 0;
  bit         sort_gap = 0;
  bit         armed = 0;
  bit         rnd_or = 0;
  bit         stall_prev = 0;
  logic [7:0] hold_a, hold_d;

  always @(negedge clk) begin
    int p;
    bit next_gap;
    cycle++;
    next_gap = 0;
    if (armed) begin
      chk("in_ready",    in_ready,    asc.size() == 0);
      chk("in_ready_d",  in_ready_d,  asc.size() == 0);
      chk("out_valid",   out_valid,   asc.size() != 0 && !sort_gap);
      chk("out_valid_d", out_valid_d, asc.size() != 0 && !sort_gap);
      chk("busy",        busy,        frame.size() != 0 || asc.size() != 0);
      chk("busy_d",      busy_d,      frame.size() != 0 || asc.size() != 0);
      if (out_valid) begin
        chk("out_last",   out_last,   beat == 7);
        chk("out_last_d", out_last_d, beat == 7);
      end
      if (stall_prev) begin
        chk("hold_data",   out_data,   hold_a);
        chk("hold_data_d", out_data_d, hold_d);
      end
      if (rst) begin
        frame.delete();
        asc.delete();
        beat = 0;
        stall_prev = 0;
      end else begin
        stall_prev = out_valid && !out_ready;
        hold_a = out_data;
        hold_d = out_data_d;
        if (out_valid && out_ready && asc.size() == 8) begin
          chk("out_data",   out_data,   asc[beat]);
          chk("out_data_d", out_data_d, asc[7 - beat]);
          beat++;
          if (beat == 8) begin
            asc.delete();
            beat = 0;
          end
        end
        if (in_valid && in_ready) begin
          if (frame.size() == 0) starts.push_back(cycle);
          frame.push_back(in_data);
          if (frame.size() == 8) begin
            asc.delete();
            foreach (frame[k]) begin
              p = 0;
              while (p < asc.size() && asc[p] <= frame[k]) p++;
              asc.insert(p, frame[k]);
            end
            frame.delete();
            next_gap = 1;
          end
        end
      end
    end
    sort_gap = next_gap;
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      out_ready = rnd_or ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  task automatic push_byte(input logic [7:0] b, input int gap_max);
    int  n;
    bit  ok;
    n = (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0;
    if (n > 0) begin
      in_valid = 1'b0;
      repeat (n) begin @(posedge clk); #1; end
    end
    in_valid = 1'b1;
    in_data  = b;
    ok = 0;
    for (int t = 0; t < 300 && !ok; t++) begin
      @(negedge clk);
      ok = in_ready && !rst;
      @(posedge clk);
      #1;
    end
    if (!ok) chk("accept_timeout", 0, 1);
  endtask

  task automatic send_frame(input logic [7:0] f [8], input int gap_max, input bit hold);
    for (int i = 0; i < 8; i++) push_byte(f[i], gap_max);
    if (!hold) in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while ((asc.size() != 0 || frame.size() != 0) && t < 400) begin
      @(posedge clk); #1; t++;
    end
    if (t == 400) chk("drain_timeout", 0, 1);
  endtask

  logic [7:0] fr [8];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    armed = 1;
    @(negedge clk);
    chk("rst_out_data",   out_data,   8'h00);
    chk("rst_out_data_d", out_data_d, 8'h00);
    chk("rst_out_last",   out_last,   1'b0);
    chk("rst_in_ready",   in_ready,   1'b1);
    @(posedge clk); #1;

    fr = '{8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1};
    send_frame(fr, 0, 0); wait_drain();

    fr = '{8'hFF, 8'h00, 8'h80, 8'h80, 8'h01, 8'hFF, 8'h00, 8'h7F};
    send_frame(fr, 0, 0); wait_drain();

    rnd_or = 1;
    fr = '{8'd3, 8'd9, 8'd1, 8'd200, 8'd45, 8'd45, 8'd0, 8'd17};
    send_frame(fr, 3, 0); wait_drain();
    rnd_or = 0;

    for (int i = 0; i < 5; i++) push_byte(8'(8'd100 + i), 0);
    in_valid = 1'b0;
    rst = 1'b1; @(posedge clk); #1 rst = 1'b0;
    fr = '{8'd80, 8'd70, 8'd60, 8'd50, 8'd40, 8'd30, 8'd20, 8'd10};
    send_frame(fr, 0, 0); wait_drain();

    fr = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8};
    send_frame(fr, 0, 0);
    for (int t = 0; t < 100 && beat < 3; t++) begin @(posedge clk); #1; end
    chk("send_beats_before_rst", beat, 3);
    rst = 1'b1; @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("post_rst_out_valid", out_valid, 1'b0);
    chk("post_rst_in_ready",  in_ready,  1'b1);
    @(posedge clk); #1;

    starts.delete();
    fr = '{8'd11, 8'd250, 8'd3, 8'd3, 8'd90, 8'd0, 8'd64, 8'd7};
    send_frame(fr, 0, 1);
    fr = '{8'd5, 8'd5, 8'd5, 8'd1, 8'd255, 8'd128, 8'd2, 8'd9};
    send_frame(fr, 0, 0); wait_drain();
    chk("b2b_frames", starts.size(), 2);
    if (starts.size() == 2) chk("b2b_spacing", starts[1] - starts[0], 17);

    rnd_or = 1;
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < 8; i++) fr[i] = 8'($urandom_range(0, (r % 2) ? 7 : 255));
      send_frame(fr, r % 4, 0); wait_drain();
    end
    rnd_or = 0;

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/sort8_stream.md
# sort8_stream

Streaming front/back end for the combinational 8-input byte sorter `sort8`. The block collects eight bytes from a valid/ready input stream and presents them in parallel to an internal `sort8` instance. It registers the sorted result and replays it as an eight-beat valid/ready output stream. It is the stage that feeds `sort8` and consumes its outputs, so the sorter can sit on a byte-serial datapath.

## Interface
- `DESCEND`, default 0: 0 emits ascending order (y0 first); 1 emits descending order (y7 first).
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `in_valid`, input, 1: `in_data` is valid this cycle.
- `in_data`, input, 8: unsigned input byte.
- `in_ready`, output, 1: block accepts a byte this cycle.
- `out_valid`, output, 1: `out_data` is valid this cycle.
- `out_data`, output, 8: sorted output byte.
- `out_last`, output, 1: marks the 8th beat of a frame; qualified by `out_valid`.
- `out_ready`, input, 1: downstream accepts `out_data` this cycle.
- `busy`, output, 1: high whenever state is not LOAD or the load count is nonzero.

## Operation
- Input transfer occurs when `in_valid && in_ready`. Output transfer occurs when `out_valid && out_ready`.
- FSM states: LOAD, SORT, SEND.
- **LOAD**
  - `in_ready`=1.
  - Each input transfer writes `in_data` to `buf[cnt]` and increments the 3-bit `cnt`.
  - The transfer with `cnt`==7 wraps `cnt` to 0 and moves the FSM to SORT.
- **SORT**
  - Exactly one cycle, with `in_ready`=0.
  - `buf[0..7]` drives `sort8` x0..x7. Outputs y0..y7 are latched into `res[0..7]`.
  - Moves to SEND.
- **SEND**
  - `out_valid`=1 and `in_ready`=0.
  - `out_data` = `res[idx]` when DESCEND=0, otherwise `res[7-idx]`.
  - `out_last` = (`idx`==7).
  - Each output transfer increments the 3-bit `idx`.
  - The transfer with `idx`==7 wraps `idx` to 0 and moves the FSM to LOAD.
- `out_valid` and `out_data` hold stable while `out_ready`=0 (no retraction, no data change).
- Equal bytes are all emitted; duplicates are preserved with multiplicity.
- Input bytes offered outside LOAD are not accepted and not lost; the upstream source holds them per the valid/ready rules.
- Frames never overlap: a new frame loads only after the previous frame's 8th output transfer.

## Timing
- **Reset values:** state=LOAD, `cnt`=0, `idx`=0, `in_ready`=1 (combinational from state), `out_valid`=0, `out_last`=0, `out_data`=0, `busy`=0. `buf`/`res` are cleared to 0.
- `rst` has priority over every other event in the same cycle. Asserting it mid-LOAD or mid-SEND discards the partial frame. The next cycle is LOAD with `cnt`=0.
- **Latency:**
  - The 8th input transfer occurs at edge N.
  - The SORT cycle runs between edges N and N+1.
  - `out_valid` rises after edge N+1.
  - With `out_ready` held high, the first byte is visible one cycle after the SORT cycle. The 8 output beats then occupy 8 consecutive cycles.
- `in_ready` rises the cycle after the `out_last` transfer.
- **Throughput:** with no stalls, 17 cycles per frame (8 load + 1 sort + 8 send).
- `in_valid` gaps during LOAD only pause `cnt`. `out_ready` gaps during SEND only pause `idx`.
- **Outputs are glitch-free:**
  - `in_ready`, `out_valid` and `out_last` are decoded from registered state and `idx` only.
  - `out_data` is a mux of registered `res`.
  - No combinational path runs from `in_valid` or `out_ready` to any output.

## Test plan
- **Ascending sort:** feed 8,7,6,5,4,3,2,1 with `out_ready`=1 and DESCEND=0. Expect output 1,2,3,4,5,6,7,8. Expect `out_last` only on the byte 8. Expect first `out_valid` exactly 2 cycles after the last input transfer.
- **Duplicates and extremes:** feed 0xFF,0x00,0x80,0x80,0x01,0xFF,0x00,0x7F. Expect output 0x00,0x00,0x01,0x7F,0x80,0x80,0xFF,0xFF.
- **Backpressure:** toggle `in_valid` and `out_ready` with a pseudo-random pattern over a frame of 3,9,1,200,45,45,0,17. Expect output 0,1,3,9,17,45,45,200. Expect `out_data` stable during every `out_ready`=0 cycle. Expect `in_ready`=0 for the whole of SORT and SEND.
- **Reset mid-frame:** load 5 bytes, assert `rst` for 1 cycle, then load 10,20,30,40,50,60,70,80 reversed. Expect output 10..80 ascending, with no trace of the earlier bytes. Also reset during SEND after 3 beats: expect `out_valid`=0 the next cycle and `in_ready`=1.
- **Back-to-back frames:** send two frames with `in_valid` held high, using a source that holds data. Expect the second frame's first `in_ready` the cycle after the first frame's `out_last` transfer, and 17-cycle frame spacing.
- **DESCEND=1:** feed 1..8. Expect output 8,7,...,1, with `out_last` on the byte 1.
